logreg_engine: RTL and testbench

Clocked, parametrised binary logistic-regression inference engine. It computes a dot product of N_FEAT signed fixed-point features with on-chip weights, adds a bias, and classifies by the sign of the result. Because sigmoid(z) >= 0.5 exactly when z >= 0, the comparison replaces the sigmoid. It is the next generation of the team's hard-wired logistic block and adds loadable weights, streamed features, a start/done handshake and a saturated score output. It sits between the feature pipeline and the classifier result logic.

---
 rtl/logreg_pkg.sv | 35 +++
 rtl/logreg_if.sv | 27 ++
 rtl/logreg_mac.sv | 32 +++
 rtl/logreg_engine.sv | 105 ++++++++++
 tb/tb_logreg_engine.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/logreg_pkg.sv
// Shared types and helpers for the logistic-regression engines.
// sat_shift is also meant for the multi-class variants, so it works on a wide fixed container.
package logreg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN,
        S_DONE
    } state_t;

    localparam int SAT_W = 128;

    function automatic int acc_w(input int n_feat, input int data_w);
        return 2 * data_w + $clog2(n_feat) + 1;
    endfunction

    // Arithmetic shift right by frac_w (floor), then clamp to a signed data_w range.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input int                       frac_w,
        input int                       data_w
    );
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sh = acc >>> frac_w;
        hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (data_w - 1));
        if (sh > hi)      return hi;
        else if (sh < lo) return lo;
        else              return sh;
    endfunction

endpackage

// File: rtl/logreg_if.sv
// Host-side bus of the logistic-regression engine: weight writes, start/done, feature stream.
interface logreg_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     start;
    logic                     feat_valid;
    logic signed [DATA_W-1:0] feat_data;
    logic                     feat_ready;
    logic                     busy;
    logic                     done;
    logic                     ypred;
    logic signed [DATA_W-1:0] z_out;

    modport master (
        output wr_en, wr_addr, wr_data, start, feat_valid, feat_data,
        input  feat_ready, busy, done, ypred, z_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, feat_valid, feat_data,
        output feat_ready, busy, done, ypred, z_out
    );
endinterface

// File: rtl/logreg_mac.sv
// Signed multiply-accumulate register: full-precision products plus a Q-aligned bias add.
module logreg_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     add_en,
    input  logic                     bias_en,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;

    assign prod     = w * x;
    assign prod_ext = ACC_W'(prod);
    // Bias is in Q(FRAC_W); products are in Q(2*FRAC_W), so align before adding.
    assign bias_ext = ACC_W'(bias) <<< FRAC_W;

    always_ff @(posedge clk) begin
        if (rst)          acc <= '0;
        else if (clr)     acc <= '0;
        else if (add_en)  acc <= acc + prod_ext;
        else if (bias_en) acc <= acc + bias_ext;
    end
endmodule

// File: rtl/logreg_engine.sv
// Binary logistic-regression classifier: streamed dot product + bias, sign decides the label.
// sigmoid(z) >= 0.5 iff z >= 0, so no sigmoid is evaluated.
module logreg_engine
    import logreg_pkg::*;
#(
    parameter int N_FEAT = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ADDR_W = 8
) (
    input logic     clk,
    input logic     rst,
    logreg_if.slave bus
);
    localparam int ACC_W = acc_w(N_FEAT, DATA_W);
    localparam int IDX_W = $clog2(N_FEAT);

    state_t                          state;
    logic [N_FEAT-1:0][DATA_W-1:0]   w_q;
    logic signed [DATA_W-1:0]        bias_q;
    logic [IDX_W-1:0]                idx;
    logic signed [ACC_W-1:0]         acc;
    logic signed [DATA_W-1:0]        z_sat;
    logic                            accept;
    logic                            ready_q, busy_q, done_q, ypred_q;
    logic signed [DATA_W-1:0]        z_q;

    assign accept = (state == S_RUN) && bus.feat_valid && ready_q;
    assign z_sat  = DATA_W'(sat_shift(SAT_W'(acc), FRAC_W, DATA_W));

    logreg_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state == S_IDLE) && bus.start),
        .add_en  (accept),
        .bias_en (state == S_FIN),
        .w       ($signed(w_q[idx])),
        .x       (bus.feat_data),
        .bias    (bias_q),
        .acc     (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            w_q     <= '0;
            bias_q  <= '0;
            idx     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ypred_q <= 1'b0;
            z_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Write lands on the same edge as start, so the run sees the new value.
                    if (bus.wr_en) begin
                        for (int i = 0; i < N_FEAT; i++)
                            if (bus.wr_addr == ADDR_W'(i)) w_q[i] <= bus.wr_data;
                        if (bus.wr_addr == ADDR_W'(N_FEAT)) bias_q <= bus.wr_data;
                    end
                    if (bus.start) begin
                        state   <= S_RUN;
                        idx     <= '0;
                        ypred_q <= 1'b0;
                        z_q     <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_W'(N_FEAT - 1)) begin
                            state   <= S_FIN;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_FIN: state <= S_DONE;
                S_DONE: begin
                    // Label comes from the full-precision sign, not the clamped score.
                    ypred_q <= ~acc[ACC_W-1];
                    z_q     <= z_sat;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.feat_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ypred      = ypred_q;
    assign bus.z_out      = z_q;
endmodule

// File: tb/tb_logreg_engine.sv
// Scoreboard bench for logreg_engine: directed scenarios then randomized runs vs. an arithmetic model.
module tb_logreg_engine;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int FW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logreg_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    logreg_engine #(.N_FEAT(N), .DATA_W(DW), .FRAC_W(FW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint z;
        longint y;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_push   = 0;
    int   n_done   = 0;
    int   mw[N];
    int   mb;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("z_out", longint'($signed(bus.z_out)), e.z);
                check("ypred", longint'(bus.ypred), e.y);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = DW'(d);
        tick();
        bus.wr_en = 1'b0;
        if (a < N)       mw[a] = d;
        else if (a == N) mb    = d;
    endtask

    // Reference: exact integer dot product, floor divide by 2^FW, clamp.
    function automatic void push_exp(input int f[N]);
        longint s;
        longint z;
        s = longint'(mb) * 256;
        for (int i = 0; i < N; i++) s += longint'(mw[i]) * longint'(f[i]);
        z = s >>> FW;
        if (z > 32767)  z = 32767;
        if (z < -32768) z = -32768;
        sb.push_back('{z, (s >= 0) ? 64'sd1 : 64'sd0});
        n_push++;
    endfunction

    task automatic start_run(input int f[N], input bit bias_wr, input int bias_v);
        if (bias_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(N);
            bus.wr_data = DW'(bias_v);
            mb          = bias_v;
        end
        push_exp(f);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic feed(input int f[N], input int nfeat, input int stall, input bit abuse,
                        output int accepts);
        bit ok;
        bit r;
        accepts = 0;
        if (abuse) begin
            bus.start   = 1'b1;
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(0);
            bus.wr_data = DW'(999);
            tick();
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
        end
        for (int i = 0; i < nfeat; i++) begin
            for (int s = 0; s < stall; s++) begin
                bus.feat_valid = 1'b0;
                @(negedge clk);
                check("ready_in_run", longint'(bus.feat_ready), 1);
                tick();
            end
            bus.feat_valid = 1'b1;
            bus.feat_data  = DW'(f[i]);
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                r = bus.feat_ready;
                tick();
                if (r) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (ok) accepts++;
            else    check("accept_timeout", 0, 1);
        end
        bus.feat_valid = 1'b0;
    endtask

    task automatic finish_run(input int accepts);
        int lat;
        bit got;
        check("accepts", accepts, N);
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_latency", got ? lat : -1, 3);
        @(negedge clk);
        check("done_pulse_width", longint'(bus.done), 0);
        tick();
    endtask

    task automatic do_run(input int f[N], input int stall, input bit bias_wr, input int bias_v,
                          input bit abuse);
        int acc_n;
        start_run(f, bias_wr, bias_v);
        feed(f, N, stall, abuse, acc_n);
        finish_run(acc_n);
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_busy"},       longint'(bus.busy), 0);
        check({tag, "_feat_ready"}, longint'(bus.feat_ready), 0);
        check({tag, "_done"},       longint'(bus.done), 0);
        check({tag, "_ypred"},      longint'(bus.ypred), 0);
        check({tag, "_z_out"},      longint'($signed(bus.z_out)), 0);
        tick();
    endtask

    task automatic load_w(input int v);
        for (int i = 0; i < N; i++) write(i, v);
    endtask

    function automatic int rnd16();
        logic signed [DW-1:0] r;
        r = DW'($urandom);
        return int'(r);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int f1[N]  = '{256, -512, 128, 0};
        int f2[N]  = '{256, -256, 0, 0};
        int fmx[N] = '{32767, 32767, 32767, 32767};
        int fr[N];
        int acc_n;

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.feat_valid = 1'b0; bus.feat_data = '0;
        for (int i = 0; i < N; i++) mw[i] = 0;
        mb  = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        // Basic, bias, exact-zero boundary
        load_w(256); write(N, 0);
        do_run(f1, 0, 1'b0, 0, 1'b0);
        write(N, 256);
        do_run(f1, 0, 1'b0, 0, 1'b0);
        write(N, 0);
        do_run(f2, 0, 1'b0, 0, 1'b0);

        // Saturation both ways
        load_w(32767);
        do_run(fmx, 0, 1'b0, 0, 1'b0);
        load_w(-32768);
        do_run(fmx, 0, 1'b0, 0, 1'b0);

        // Stalls, protocol abuse in RUN, bias write together with start
        load_w(256);
        do_run(f1, 3, 1'b0, 0, 1'b0);
        do_run(f1, 0, 1'b0, 0, 1'b1);
        do_run(f1, 0, 1'b1, 256, 1'b0);

        // Reset mid-run clears everything, including weights
        write(N, 0);
        start_run(f1, 1'b0, 0);
        feed(f1, 2, 0, 1'b0, acc_n);
        check("accepts_before_reset", acc_n, 2);
        rst = 1'b1;
        void'(sb.pop_back());
        n_push--;
        for (int i = 0; i < N; i++) mw[i] = 0;
        mb = 0;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrun_reset");
        do_run(f1, 0, 1'b0, 0, 1'b0);

        // Randomized runs, including writes to unmapped addresses
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 4) == 0) write(int'($urandom_range(N + 1, 255)), rnd16());
                else                           write(int'($urandom_range(0, N)), rnd16());
            end
            for (int i = 0; i < N; i++) fr[i] = rnd16();
            do_run(fr, int'($urandom_range(0, 2)), 1'b0, 0, 1'b0);
        end

        repeat (4) tick();
        check("scoreboard_empty", sb.size(), 0);
        check("done_count", n_done, n_push);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
